// File: rtl/ord_tx_if.sv
// ord_tx_if: order-in / Avalon-ST-out bundle for ord_tx
//   slave  : ord_tx side (takes orders, sources the stream, reports drops)
//   master : strategy/MAC side (sources orders, sinks the stream)
//   ORD_TX_KILL_EN adds the kill input to both modports
interface ord_tx_if #(parameter int OUT_WIDTH = 64);
   logic                   ord_valid;
   logic [2*OUT_WIDTH-1:0] ord_data;
   logic                   ord_ready;
   logic                   out_valid;
   logic                   out_ready;
   logic [OUT_WIDTH-1:0]   out_data;
   logic                   out_sop;
   logic                   out_eop;
   logic [2:0]             out_empty;
   logic                   ovf_err;
   logic [7:0]             drop_cnt;
`ifdef ORD_TX_KILL_EN
   logic                   kill;
`endif
   modport slave (
`ifdef ORD_TX_KILL_EN
      input kill,
`endif
      input ord_valid, ord_data, out_ready,
      output ord_ready, out_valid, out_data, out_sop, out_eop, out_empty, ovf_err, drop_cnt
   );
   modport master (
`ifdef ORD_TX_KILL_EN
      output kill,
`endif
      output ord_valid, ord_data, out_ready,
      input ord_ready, out_valid, out_data, out_sop, out_eop, out_empty, ovf_err, drop_cnt
   );
endinterface

// File: rtl/ord_tx.sv
// ord_tx: buffers strategy orders in a FIFO and frames each as a 3-beat Avalon-ST packet
//   clk, reset : core clock, synchronous active-high reset
//   bus.ord_*  : order input (valid/data/ready); ready drops SKID entries early
//   bus.out_*  : 64-bit stream, beats HDR{seq,len,0} / order[127:64] / order[63:0]
//   bus.ovf_err, bus.drop_cnt : sticky overflow flag, saturating drop count
//   ORD_TX_KILL_EN : adds bus.kill, which flushes queued orders and drops new ones
module ord_tx #(
   parameter int ORD_WIDTH  = 128,
   parameter int OUT_WIDTH  = 64,
   parameter int FIFO_DEPTH = 8,
   parameter int SKID       = 2,
   parameter int SEQ_WIDTH  = 16
) (
   input logic    clk,
   input logic    reset,
   ord_tx_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {IDLE, HDR, HI, LO} state_t;
   state_t                 state, state_nxt;
   logic [ORD_WIDTH-1:0]   mem [FIFO_DEPTH];
   logic [ORD_WIDTH-1:0]   head;
   logic [AW-1:0]          rd_ptr, wr_ptr;
   logic [CW-1:0]          count, count_nxt;
   logic [SEQ_WIDTH-1:0]   seq;
   logic                   kill_i, full, pop, push, drop, keep;
`ifdef ORD_TX_KILL_EN
   assign kill_i = bus.kill;
`else
   assign kill_i = 1'b0;
`endif
   assign head = mem[rd_ptr];
   assign full = count == CW'(FIFO_DEPTH);
   assign pop  = state == LO && bus.out_ready;
   // A full FIFO still takes an order when the head leaves on the same edge
   assign push = bus.ord_valid && !kill_i && (!full || pop);
   assign drop = bus.ord_valid && !kill_i && full && !pop;
   // Under kill only the packet already past its header survives the flush
   assign keep = kill_i && (state == HI || (state == LO && !bus.out_ready) || (state == HDR && bus.out_ready));
   assign count_nxt = kill_i ? CW'(keep) : count + CW'(push) - CW'(pop);
   assign bus.ord_ready = kill_i || count < CW'(FIFO_DEPTH - SKID);
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= bus.ord_data;
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         seq          <= '0;
         bus.ovf_err  <= 1'b0;
         bus.drop_cnt <= '0;
      end else begin
         rd_ptr <= rd_ptr + AW'(pop);
         wr_ptr <= kill_i ? rd_ptr + AW'(pop) + AW'(keep) : wr_ptr + AW'(push);
         count  <= count_nxt;
         seq    <= seq + SEQ_WIDTH'(pop);
         if (drop) bus.ovf_err <= 1'b1;
         if (drop && bus.drop_cnt != 8'hFF) bus.drop_cnt <= bus.drop_cnt + 8'd1;
      end
   end
   always_ff @(posedge clk)
      state <= reset ? IDLE : state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = (count != '0 && !kill_i) ? HDR : IDLE;
         HDR:     state_nxt = bus.out_ready ? HI : kill_i ? IDLE : HDR;
         HI:      state_nxt = bus.out_ready ? LO : HI;
         default: state_nxt = !bus.out_ready ? LO : count_nxt != '0 ? HDR : IDLE;
      endcase
   end
   always_comb begin
      bus.out_valid = state != IDLE;
      bus.out_sop   = state == HDR;
      bus.out_eop   = state == LO;
      bus.out_empty = '0;
      bus.out_data  = state == HDR ? {16'(seq), 16'h0010, {(OUT_WIDTH-32){1'b0}}} :
                      state == HI  ? head[ORD_WIDTH-1:OUT_WIDTH] :
                      state == LO  ? head[OUT_WIDTH-1:0] : '0;
   end
endmodule
